// File: rtl/sr_flag_bank_arbiter_if.sv
// Handshake bundle between requesters, the SR flag bank and the arbiter.
// Requester side: req/op/addr in, gnt/done/rdata/err back. Bank side: q_vec in, s_vec/r_vec out.
// busy reports that an operation is in flight.
interface sr_flag_bank_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int AW     = 3
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [AW*NREQ-1:0] addr;
    logic [NFLAGS-1:0]  q_vec;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               rdata;
    logic               err;
    logic [NFLAGS-1:0]  s_vec;
    logic [NFLAGS-1:0]  r_vec;
    logic               busy;

    // Control logic plus flag bank side.
    modport master (
        output req, op, addr, q_vec,
        input  gnt, done, rdata, err, s_vec, r_vec, busy
    );

    // Arbiter side.
    modport slave (
        input  req, op, addr, q_vec,
        output gnt, done, rdata, err, s_vec, r_vec, busy
    );
endinterface

// File: rtl/sr_flag_bank_arbiter.sv
// Round-robin arbiter sequencing set/clear/toggle/read operations onto a bank of SR flops.
// Latency from winning IDLE cycle: write DONE at +3+PULSE_CYC, read/bad address DONE at +2.
// Backpressure: one operation at a time; other requesters wait with req held, gnt stays one-hot.
// Ports: clk, rst (sync, active-high); bus = slave side of sr_flag_bank_arbiter_if.
module sr_flag_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int NFLAGS    = 8,
    parameter int AW        = 3,
    parameter int PULSE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sr_flag_bank_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(PULSE_CYC + 1);

    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        DRIVE,
        GAP,
        DONE_S
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [1:0]        op_l;
    logic [AW-1:0]     addr_l;
    logic              target;
    logic [CW-1:0]     cnt;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              rdata;
    logic              err;
    logic [NFLAGS-1:0] s_vec;
    logic [NFLAGS-1:0] r_vec;
    logic              busy;

    // Rotating search starting one past the last winner.
    logic              found;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     scan_idx;
    logic [1:0]        op_pick;
    logic [AW-1:0]     addr_pick;

    always_comb begin
        found    = 1'b0;
        pick     = ptr;
        scan_idx = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        op_pick   = '0;
        addr_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PW'(i)) begin
                op_pick   = bus.op[2*i +: 2];
                addr_pick = bus.addr[AW*i +: AW];
            end
        end
    end

    // One-hot decode of the latched address; all-zero means out of range,
    // so an illegal address can never index q_vec or pulse a bank bit.
    logic [NFLAGS-1:0] sel;
    logic              addr_ok;
    logic              q_sel;
    logic              wr_target;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (addr_l == AW'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

    assign addr_ok = |sel;
    assign q_sel   = |(bus.q_vec & sel);

    always_comb begin
        case (op_l)
            OP_SET:  wr_target = 1'b1;
            OP_CLR:  wr_target = 1'b0;
            default: wr_target = ~q_sel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= PW'(NREQ - 1);
            op_l   <= '0;
            addr_l <= '0;
            target <= 1'b0;
            cnt    <= '0;
            gnt    <= '0;
            done   <= '0;
            rdata  <= 1'b0;
            err    <= 1'b0;
            s_vec  <= '0;
            r_vec  <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        ptr    <= pick;
                        op_l   <= op_pick;
                        addr_l <= addr_pick;
                        gnt    <= NREQ'(1) << pick;
                        busy   <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    rdata <= q_sel;
                    if (!addr_ok || op_l == OP_RD) begin
                        done  <= gnt;
                        err   <= ~addr_ok;
                        state <= DONE_S;
                    end else begin
                        target <= wr_target;
                        s_vec  <= wr_target ? sel : '0;
                        r_vec  <= wr_target ? '0 : sel;
                        cnt    <= CW'(1);
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CW'(PULSE_CYC)) begin
                        s_vec <= '0;
                        r_vec <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    // Bank has settled with S/R both low; verify the write landed.
                    done  <= gnt;
                    err   <= (q_sel != target);
                    state <= DONE_S;
                end
                DONE_S: begin
                    done  <= '0;
                    err   <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.done  = done;
    assign bus.rdata = rdata;
    assign bus.err   = err;
    assign bus.s_vec = s_vec;
    assign bus.r_vec = r_vec;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_sr_flag_bank_arbiter.sv
// Bench for sr_flag_bank_arbiter: vector table, held-request and mid-op reset sequences,
// then random operations compared against an operation-level model of the flag bank.
// The flag bank is modelled as SR flops updated from s_vec/r_vec, with an optional stuck-at-0 mask.
module tb_sr_flag_bank_arbiter;
    localparam int NREQ      = 4;
    localparam int NFLAGS    = 8;
    localparam int AW        = 4;
    localparam int PULSE_CYC = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sr_flag_bank_arbiter_if #(.NREQ(NREQ), .NFLAGS(NFLAGS), .AW(AW)) bus ();

    sr_flag_bank_arbiter #(
        .NREQ(NREQ), .NFLAGS(NFLAGS), .AW(AW), .PULSE_CYC(PULSE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Flag bank model.
    logic [7:0] q_bank;
    logic [7:0] stuck0;
    logic [7:0] q_load_val;
    logic       q_load_en;

    always @(posedge clk) begin
        if (q_load_en) begin
            q_bank <= q_load_val;
        end else begin
            for (int i = 0; i < NFLAGS; i++) begin
                if (bus.s_vec[i])      q_bank[i] <= 1'b1;
                else if (bus.r_vec[i]) q_bank[i] <= 1'b0;
            end
        end
    end
    assign bus.q_vec = q_bank & ~stuck0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle and sample away from the edge, checking the bank-safety invariants.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("s_and_r_overlap", {24'b0, bus.s_vec & bus.r_vec}, 32'h0);
        chk("sr_onehot0", 32'($countones(bus.s_vec | bus.r_vec) <= 1), 32'h1);
        chk("gnt_onehot0", 32'($countones(bus.gnt) <= 1), 32'h1);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One isolated operation: preload the bank, raise req, drop it once granted,
    // then check grant, latency, S/R activity, completion flags and the final flag values.
    task automatic run_op(input string tag, input logic [3:0] req, input logic [7:0] op,
                          input logic [15:0] addr, input logic [7:0] q_init, input logic [7:0] stuck,
                          input logic [3:0] exp_gnt, input int exp_lat, input logic [7:0] exp_s,
                          input logic [7:0] exp_r, input logic chk_rd, input logic exp_rd,
                          input logic exp_err, input logic [7:0] exp_q);
        logic [3:0] g1, done_v;
        logic       busy1, rd, er;
        logic [7:0] s_seen, r_seen;
        int         lat;
        q_load_val = q_init;
        stuck0     = stuck;
        q_load_en  = 1'b1;
        tick();
        q_load_en = 1'b0;
        bus.req  = req;
        bus.op   = op;
        bus.addr = addr;
        s_seen = '0; r_seen = '0; lat = -1; g1 = '0; busy1 = 1'b0;
        done_v = '0; rd = 1'b0; er = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) begin
                g1      = bus.gnt;
                busy1   = bus.busy;
                bus.req = '0;
            end
            s_seen |= bus.s_vec;
            r_seen |= bus.r_vec;
            if (bus.done != 0) begin
                lat    = n;
                done_v = bus.done;
                rd     = bus.rdata;
                er     = bus.err;
                break;
            end
        end
        chk({tag, ".gnt"}, {28'b0, g1}, {28'b0, exp_gnt});
        chk({tag, ".busy"}, {31'b0, busy1}, 32'h1);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".done"}, {28'b0, done_v}, {28'b0, exp_gnt});
        chk({tag, ".s_vec"}, {24'b0, s_seen}, {24'b0, exp_s});
        chk({tag, ".r_vec"}, {24'b0, r_seen}, {24'b0, exp_r});
        if (chk_rd) chk({tag, ".rdata"}, {31'b0, rd}, {31'b0, exp_rd});
        chk({tag, ".err"}, {31'b0, er}, {31'b0, exp_err});
        tick();
        chk({tag, ".q_after"}, {24'b0, bus.q_vec}, {24'b0, exp_q});
        chk({tag, ".idle_after"}, {27'b0, bus.busy, bus.gnt}, 32'h0);
    endtask

    // Operation-level reference: rotating pick, then the effect of the winner's
    // opcode on the visible flag values.
    task automatic model(input logic [3:0] req, input logic [7:0] op, input logic [15:0] addr,
                         input logic [7:0] qb, input logic [7:0] st, input int ptr,
                         output int win, output logic [3:0] g, output int lat,
                         output logic [7:0] es, output logic [7:0] er, output logic crd,
                         output logic erd, output logic eerr, output logic [7:0] eq);
        int         o, a;
        logic       t;
        logic [7:0] vis, nb;
        win = -1;
        for (int k = 1; k <= NREQ; k++)
            if (win < 0 && req[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
        o   = (int'(op) >> (2 * win)) & 3;
        a   = (int'(addr) >> (4 * win)) & 15;
        vis = qb & ~st;
        g   = 4'(1 << win);
        es = '0; er = '0; crd = 1'b0; erd = 1'b0; eerr = 1'b0; eq = vis;
        if (a >= NFLAGS) begin
            lat  = 2;
            eerr = 1'b1;
        end else if (o == 3) begin
            lat = 2;
            crd = 1'b1;
            erd = vis[a];
        end else begin
            t   = (o == 0) ? 1'b1 : (o == 1) ? 1'b0 : ~vis[a];
            lat = 3 + PULSE_CYC;
            if (t) es = 8'(1 << a);
            else   er = 8'(1 << a);
            nb    = qb;
            nb[a] = t;
            eq    = nb & ~st;
            eerr  = (eq[a] != t);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  op;
        logic [15:0] addr;
        logic [7:0]  q_init;
        logic [7:0]  stuck;
        logic [3:0]  gnt;
        int          lat;
        logic [7:0]  s;
        logic [7:0]  r;
        logic        crd;
        logic        rd;
        logic        err;
        logic [7:0]  q;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int         ndone, ref_ptr, win, lat, idx;
        int         ord[5];
        logic [3:0] g, rq;
        logic [7:0] es, er, eq, op, qi, st;
        logic [15:0] ad;
        logic       crd, erd, eerr, seen;

        // Rows run back to back after one reset, so the pointer carries between rows.
        tbl[0] = '{4'b0001, 8'h00, 16'h0005, 8'h00, 8'h00, 4'b0001, 4, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20};
        tbl[1] = '{4'b1000, 8'hC0, 16'h2000, 8'h04, 8'h00, 4'b1000, 2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04};
        tbl[2] = '{4'b0001, 8'h00, 16'h0009, 8'h00, 8'h00, 4'b0001, 2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[3] = '{4'b0010, 8'h00, 16'h0010, 8'h00, 8'h02, 4'b0010, 4, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[4] = '{4'b0100, 8'h10, 16'h0700, 8'h80, 8'h00, 4'b0100, 4, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{4'b0110, 8'h08, 16'h0030, 8'h08, 8'h00, 4'b0010, 4, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{4'b1111, 8'h20, 16'h0000, 8'h00, 8'h00, 4'b0100, 4, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01};

        q_load_en  = 1'b0;
        q_load_val = '0;
        stuck0     = '0;
        bus.op     = '0;
        bus.addr   = '0;
        do_reset();
        chk("reset.outputs", {13'b0, bus.gnt, bus.done, bus.rdata, bus.err, bus.busy},  32'h0);
        chk("reset.sr", {16'b0, bus.s_vec, bus.r_vec}, 32'h0);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), tbl[i].req, tbl[i].op, tbl[i].addr, tbl[i].q_init,
                   tbl[i].stuck, tbl[i].gnt, tbl[i].lat, tbl[i].s, tbl[i].r, tbl[i].crd,
                   tbl[i].rd, tbl[i].err, tbl[i].q);

        // All four requesters held with toggles on flags 0..3: five grants rotate 0,1,2,3,0.
        do_reset();
        stuck0 = '0; q_load_val = '0; q_load_en = 1'b1; tick(); q_load_en = 1'b0;
        bus.op = 8'hAA; bus.addr = 16'h3210; bus.req = 4'b1111;
        ndone = 0;
        for (int n = 0; n < 60 && ndone < 5; n++) begin
            tick();
            if (bus.done != 0) begin
                idx = -1;
                for (int j = 0; j < NREQ; j++) if (bus.done[j]) idx = j;
                ord[ndone] = idx;
                ndone++;
                if (ndone == 5) bus.req = '0;
            end
        end
        chk("held.count", ndone, 5);
        for (int j = 0; j < 5; j++)
            if (j < ndone) chk($sformatf("held.order%0d", j), ord[j], j % 4);
        tick();
        tick();
        chk("held.q", {24'b0, bus.q_vec}, 32'h0E);

        // Reset during DRIVE aborts cleanly and restores requester 0 as top priority.
        q_load_val = '0; q_load_en = 1'b1; tick(); q_load_en = 1'b0;
        bus.op = 8'h00; bus.addr = 16'h0600; bus.req = 4'b0100;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.s_vec != 0) seen = 1'b1;
        end
        chk("rstmid.drive_seen", {31'b0, seen}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rstmid.sr", {16'b0, bus.s_vec, bus.r_vec}, 32'h0);
        chk("rstmid.outputs", {13'b0, bus.gnt, bus.done, bus.rdata, bus.err, bus.busy}, 32'h0);
        rst = 1'b0; bus.req = '0;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.done != 0) seen = 1'b1;
        end
        chk("rstmid.no_done", {31'b0, seen}, 32'h0);
        run_op("rstmid.next", 4'b1001, 8'h00, 16'h3002, 8'h00, 8'h00, 4'b0001, 4,
               8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);

        // Random operations against the reference model.
        ref_ptr = 0;
        for (int it = 0; it < 60; it++) begin
            rq = 4'($urandom_range(1, 15));
            op = 8'($urandom);
            for (int j = 0; j < NREQ; j++) ad[4*j +: 4] = 4'($urandom_range(0, 9));
            qi = 8'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            model(rq, op, ad, qi, st, ref_ptr, win, g, lat, es, er, crd, erd, eerr, eq);
            run_op($sformatf("rnd%0d", it), rq, op, ad, qi, st, g, lat, es, er, crd, erd, eerr, eq);
            ref_ptr = win;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
